// File: rtl/traffic_phase_sequencer.sv
// Timed NS/EW intersection phase controller with pedestrian walk service and night flash.
// Paced by the synchronized rising edge of the slow 5 Hz divider output; all outputs registered.
module traffic_phase_sequencer #(
  parameter int T_GREEN    = 50,
  parameter int T_YELLOW   = 15,
  parameter int T_ALLRED   = 5,
  parameter int T_WALK     = 25,
  parameter int FLASH_HALF = 3,
  parameter int CNT_W      = 8
) (
  input  logic             CLK_50MHz,
  input  logic             RESET,
  input  logic             tick_in,
  input  logic             ped_req,
  input  logic             flash_mode,
  output logic [2:0]       color,
  output logic [2:0]       ew_color,
  output logic [3:0]       squares,
  output logic [CNT_W-1:0] phase_remaining,
  output logic             ped_pending
);

  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, WALK, FLASH
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic logic [CNT_W-1:0] phaseDur(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   phaseDur = CNT_W'(T_GREEN);
      NS_YELLOW, EW_YELLOW: phaseDur = CNT_W'(T_YELLOW);
      ALLRED_A, ALLRED_B:   phaseDur = CNT_W'(T_ALLRED);
      WALK:                 phaseDur = CNT_W'(T_WALK);
      default:              phaseDur = CNT_W'(FLASH_HALF);
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             flashPhase_q, flashPhase_d;
  logic             pedPending_q, pedPending_d;
  logic [2:0]       tickSync_q, pedSync_q;
  logic [1:0]       flashSync_q;
  logic [2:0]       color_q, color_d, ewColor_q, ewColor_d;
  logic [3:0]       squares_q, squares_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] dur;
  logic             tickEn, pedEdge, flashOn;

  // The third stage of each edge-detected input only remembers the previous synchronized level.
  assign tickEn  = tickSync_q[1] & ~tickSync_q[2];
  assign pedEdge = pedSync_q[1] & ~pedSync_q[2];
  assign flashOn = flashSync_q[1];

  always_ff @(posedge CLK_50MHz or posedge RESET) begin
    if (RESET) begin
      tickSync_q  <= '0;
      pedSync_q   <= '0;
      flashSync_q <= '0;
    end else begin
      tickSync_q  <= {tickSync_q[1:0], tick_in};
      pedSync_q   <= {pedSync_q[1:0], ped_req};
      flashSync_q <= {flashSync_q[0], flash_mode};
    end
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    flashPhase_d = flashPhase_q;
    pedPending_d = pedPending_q;
    dur          = phaseDur(state_q);
    if (pedEdge && state_q != WALK) pedPending_d = 1'b1;
    // Flash preempts everything, including a phase expiry in the same cycle.
    if (flashOn && state_q != FLASH) begin
      state_d      = FLASH;
      counter_d    = '0;
      flashPhase_d = 1'b0;
    end else if (tickEn) begin
      if (state_q == FLASH && !flashOn) begin
        state_d      = ALLRED_B;
        counter_d    = '0;
        flashPhase_d = 1'b0;
      end else if (counter_q == dur - ONE) begin
        counter_d = '0;
        case (state_q)
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = ALLRED_A;
          ALLRED_A:  state_d = EW_GREEN;
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = ALLRED_B;
          ALLRED_B: begin
            // Decision uses the already-latched request, so a same-cycle press waits a cycle.
            if (pedPending_q) begin
              state_d      = WALK;
              pedPending_d = 1'b0;
            end else begin
              state_d = NS_GREEN;
            end
          end
          WALK:      state_d = NS_GREEN;
          default:   flashPhase_d = ~flashPhase_q;
        endcase
      end else begin
        counter_d = counter_q + ONE;
      end
    end
  end

  // Outputs are decoded from next-state values so they register alongside the state.
  always_comb begin
    color_d     = LAMP_R;
    ewColor_d   = LAMP_R;
    squares_d   = 4'b0000;
    remaining_d = phaseDur(state_d) - counter_d;
    case (state_d)
      NS_GREEN:  begin color_d   = LAMP_G; squares_d = 4'b0001; end
      NS_YELLOW: begin color_d   = LAMP_Y; squares_d = 4'b0001; end
      EW_GREEN:  begin ewColor_d = LAMP_G; squares_d = 4'b0010; end
      EW_YELLOW: begin ewColor_d = LAMP_Y; squares_d = 4'b0010; end
      WALK:      squares_d = 4'b0100;
      FLASH: begin
        color_d     = flashPhase_d ? LAMP_Y : 3'b000;
        ewColor_d   = flashPhase_d ? LAMP_Y : 3'b000;
        squares_d   = 4'b1000;
        remaining_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50MHz or posedge RESET) begin
    if (RESET) begin
      state_q      <= ALLRED_B;
      counter_q    <= '0;
      flashPhase_q <= 1'b0;
      pedPending_q <= 1'b0;
      color_q      <= LAMP_R;
      ewColor_q    <= LAMP_R;
      squares_q    <= 4'b0000;
      remaining_q  <= CNT_W'(T_ALLRED);
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      flashPhase_q <= flashPhase_d;
      pedPending_q <= pedPending_d;
      color_q      <= color_d;
      ewColor_q    <= ewColor_d;
      squares_q    <= squares_d;
      remaining_q  <= remaining_d;
    end
  end

  assign color           = color_q;
  assign ew_color        = ewColor_q;
  assign squares         = squares_q;
  assign phase_remaining = remaining_q;
  assign ped_pending     = pedPending_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: phase cycle, pedestrian service, flash, and reset.
module tb_traffic_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       tickIn;
  logic       pedReq;
  logic       flashMode;
  logic [2:0] color;
  logic [2:0] ewColor;
  logic [3:0] squares;
  logic [7:0] phaseRemaining;
  logic       pedPending;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  traffic_phase_sequencer dut (
    .CLK_50MHz      (clock),
    .RESET          (reset),
    .tick_in        (tickIn),
    .ped_req        (pedReq),
    .flash_mode     (flashMode),
    .color          (color),
    .ew_color       (ewColor),
    .squares        (squares),
    .phase_remaining(phaseRemaining),
    .ped_pending    (pedPending)
  );

  // One tick: raise tick_in long enough to pass the synchronizer, then drop it.
  task automatic applyStimulus(input int nTicks);
    for (int i = 0; i < nTicks; i++) begin
      @(negedge clock) tickIn = 1'b1;
      repeat (3) @(negedge clock);
      tickIn = 1'b0;
      repeat (3) @(negedge clock);
    end
  endtask

  task automatic pulsePed();
    @(negedge clock) pedReq = 1'b1;
    repeat (4) @(negedge clock);
    pedReq = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] expColor, input logic [2:0] expEw,
                             input logic [3:0] expSq, input logic [7:0] expRem, input logic expPed);
    assertCount++;
    assert ({color, ewColor, squares, phaseRemaining, pedPending} ===
            {expColor, expEw, expSq, expRem, expPed})
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed color=%b ew=%b sq=%b rem=%0d ped=%b, expected color=%b ew=%b sq=%b rem=%0d ped=%b",
             tag, color, ewColor, squares, phaseRemaining, pedPending,
             expColor, expEw, expSq, expRem, expPed);
    end
  endtask

  // Checks a phase on entry and on its last tick, then advances into the next phase.
  task automatic checkPhase(input string tag, input logic [2:0] c, input logic [2:0] e,
                            input logic [3:0] s, input int dur, input logic ped);
    checkOutput({tag, " entry"}, c, e, s, 8'(dur), ped);
    applyStimulus(dur - 1);
    checkOutput({tag, " last"}, c, e, s, 8'd1, ped);
    applyStimulus(1);
  endtask

  task automatic runCycle(input logic ped);
    checkPhase("ns green",  3'b001, 3'b100, 4'b0001, 50, ped);
    checkPhase("ns yellow", 3'b010, 3'b100, 4'b0001, 15, ped);
    checkPhase("allred a",  3'b100, 3'b100, 4'b0000, 5,  ped);
    checkPhase("ew green",  3'b100, 3'b001, 4'b0010, 50, ped);
    checkPhase("ew yellow", 3'b100, 3'b010, 4'b0010, 15, ped);
    checkPhase("allred b",  3'b100, 3'b100, 4'b0000, 5,  ped);
  endtask

  // Outside flash, at least one approach must always show red.
  always @(negedge clock) begin
    if (!squares[3]) begin
      assertCount++;
      assert (color === 3'b100 || ewColor === 3'b100)
      else begin
        failCount++;
        $error("[TB] FAIL invariant: observed color=%b ew=%b, expected at least one red (100)",
               color, ewColor);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    tickIn    = 1'b0;
    pedReq    = 1'b0;
    flashMode = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset state", 3'b100, 3'b100, 4'b0000, 8'd5, 1'b0);
    reset = 1'b0;

    $display("[TB] free-run cycle");
    checkPhase("allred b after reset", 3'b100, 3'b100, 4'b0000, 5, 1'b0);
    runCycle(1'b0);

    $display("[TB] pedestrian request during NS green");
    applyStimulus(10);
    pulsePed();
    checkOutput("ped latched", 3'b001, 3'b100, 4'b0001, 8'd40, 1'b1);
    applyStimulus(40);
    checkPhase("ns yellow ped", 3'b010, 3'b100, 4'b0001, 15, 1'b1);
    checkPhase("allred a ped",  3'b100, 3'b100, 4'b0000, 5,  1'b1);
    checkPhase("ew green ped",  3'b100, 3'b001, 4'b0010, 50, 1'b1);
    checkPhase("ew yellow ped", 3'b100, 3'b010, 4'b0010, 15, 1'b1);
    checkPhase("allred b ped",  3'b100, 3'b100, 4'b0000, 5,  1'b1);
    checkPhase("walk",          3'b100, 3'b100, 4'b0100, 25, 1'b0);

    $display("[TB] collapsed requests and request during walk");
    checkPhase("ns green 2",  3'b001, 3'b100, 4'b0001, 50, 1'b0);
    checkPhase("ns yellow 2", 3'b010, 3'b100, 4'b0001, 15, 1'b0);
    checkPhase("allred a 2",  3'b100, 3'b100, 4'b0000, 5,  1'b0);
    checkOutput("ew green 2 entry", 3'b100, 3'b001, 4'b0010, 8'd50, 1'b0);
    pulsePed();
    pulsePed();
    pulsePed();
    checkOutput("three presses", 3'b100, 3'b001, 4'b0010, 8'd50, 1'b1);
    applyStimulus(50);
    checkPhase("ew yellow 2", 3'b100, 3'b010, 4'b0010, 15, 1'b1);
    checkPhase("allred b 2",  3'b100, 3'b100, 4'b0000, 5,  1'b1);
    checkOutput("walk 2 entry", 3'b100, 3'b100, 4'b0100, 8'd25, 1'b0);
    applyStimulus(5);
    pulsePed();
    checkOutput("press in walk ignored", 3'b100, 3'b100, 4'b0100, 8'd20, 1'b0);
    applyStimulus(20);
    runCycle(1'b0);

    $display("[TB] night flash");
    applyStimulus(20);
    checkOutput("ns green tick 20", 3'b001, 3'b100, 4'b0001, 8'd30, 1'b0);
    @(negedge clock) flashMode = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("flash not yet", 3'b001, 3'b100, 4'b0001, 8'd30, 1'b0);
    @(negedge clock);
    checkOutput("flash entry", 3'b000, 3'b000, 4'b1000, 8'd0, 1'b0);
    applyStimulus(2);
    checkOutput("flash dark t2", 3'b000, 3'b000, 4'b1000, 8'd0, 1'b0);
    applyStimulus(1);
    checkOutput("flash lit t3", 3'b010, 3'b010, 4'b1000, 8'd0, 1'b0);
    applyStimulus(3);
    checkOutput("flash dark t6", 3'b000, 3'b000, 4'b1000, 8'd0, 1'b0);
    applyStimulus(3);
    checkOutput("flash lit t9", 3'b010, 3'b010, 4'b1000, 8'd0, 1'b0);
    @(negedge clock) flashMode = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("flash held until tick", 3'b010, 3'b010, 4'b1000, 8'd0, 1'b0);
    applyStimulus(1);
    checkPhase("allred b after flash", 3'b100, 3'b100, 4'b0000, 5, 1'b0);

    $display("[TB] pedestrian edge coinciding with allred b expiry");
    checkPhase("ns green 3",  3'b001, 3'b100, 4'b0001, 50, 1'b0);
    checkPhase("ns yellow 3", 3'b010, 3'b100, 4'b0001, 15, 1'b0);
    checkPhase("allred a 3",  3'b100, 3'b100, 4'b0000, 5,  1'b0);
    checkPhase("ew green 3",  3'b100, 3'b001, 4'b0010, 50, 1'b0);
    checkPhase("ew yellow 3", 3'b100, 3'b010, 4'b0010, 15, 1'b0);
    checkOutput("allred b 3 entry", 3'b100, 3'b100, 4'b0000, 8'd5, 1'b0);
    applyStimulus(4);
    checkOutput("allred b 3 last", 3'b100, 3'b100, 4'b0000, 8'd1, 1'b0);
    @(negedge clock);
    tickIn = 1'b1;
    pedReq = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("same-cycle press not served", 3'b001, 3'b100, 4'b0001, 8'd50, 1'b1);
    tickIn = 1'b0;
    pedReq = 1'b0;
    repeat (3) @(negedge clock);
    applyStimulus(49);
    checkOutput("ns green 4 last", 3'b001, 3'b100, 4'b0001, 8'd1, 1'b1);
    applyStimulus(1);
    checkPhase("ns yellow 4", 3'b010, 3'b100, 4'b0001, 15, 1'b1);
    checkPhase("allred a 4",  3'b100, 3'b100, 4'b0000, 5,  1'b1);
    checkPhase("ew green 4",  3'b100, 3'b001, 4'b0010, 50, 1'b1);
    checkPhase("ew yellow 4", 3'b100, 3'b010, 4'b0010, 15, 1'b1);
    checkPhase("allred b 4",  3'b100, 3'b100, 4'b0000, 5,  1'b1);
    checkPhase("walk 3",      3'b100, 3'b100, 4'b0100, 25, 1'b0);

    $display("[TB] asynchronous reset mid EW green");
    checkPhase("ns green 5",  3'b001, 3'b100, 4'b0001, 50, 1'b0);
    checkPhase("ns yellow 5", 3'b010, 3'b100, 4'b0001, 15, 1'b0);
    checkPhase("allred a 5",  3'b100, 3'b100, 4'b0000, 5,  1'b0);
    applyStimulus(10);
    pulsePed();
    checkOutput("ew green before reset", 3'b100, 3'b001, 4'b0010, 8'd40, 1'b1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 checkOutput("async reset", 3'b100, 3'b100, 4'b0000, 8'd5, 1'b0);
    @(negedge clock) reset = 1'b0;
    checkPhase("allred b after reset 2", 3'b100, 3'b100, 4'b0000, 5, 1'b0);
    checkOutput("ns green after reset", 3'b001, 3'b100, 4'b0001, 8'd50, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
